// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer between issue and the register file.
// Entries are allocated at issue, completed from the CDB and retired from the head one per cycle.
// Optional feature: define ROB_OPERAND_FWD_EN to add combinational operand query ports
// (qry_tag1/2 -> qry_ready1/2, qry_val1/2) with same-cycle CDB forwarding.
module reorder_buffer #(
  parameter int unsigned ROB_SIZE_BIT = 3
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    issue_valid,
  input  logic [1:0]              issue_type,
  input  logic [4:0]              issue_rd,
  input  logic                    issue_ready,
  input  logic [31:0]             issue_val,
  input  logic                    issue_pred_jump,
  output logic                    rob_full,
  output logic [ROB_SIZE_BIT-1:0] rob_tail,
  input  logic                    cdb_valid,
  input  logic [ROB_SIZE_BIT-1:0] cdb_tag,
  input  logic [31:0]             cdb_val,
  input  logic                    cdb_jump,
  input  logic [31:0]             cdb_addr,
`ifdef ROB_OPERAND_FWD_EN
  input  logic [ROB_SIZE_BIT-1:0] qry_tag1,
  input  logic [ROB_SIZE_BIT-1:0] qry_tag2,
  output logic                    qry_ready1,
  output logic                    qry_ready2,
  output logic [31:0]             qry_val1,
  output logic [31:0]             qry_val2,
`endif
  output logic [4:0]              rob_set_idx,
  output logic [31:0]             rob_set_reg_val,
  output logic [ROB_SIZE_BIT-1:0] rob_set_recorder,
  output logic                    store_go,
  output logic [ROB_SIZE_BIT-1:0] store_tag,
  output logic                    rob_clear,
  output logic [31:0]             clear_pc
);

  localparam int unsigned TAG_W    = ROB_SIZE_BIT;
  localparam int unsigned CNT_W    = ROB_SIZE_BIT + 1;
  localparam int unsigned ROB_SIZE = 1 << ROB_SIZE_BIT;

  localparam logic [1:0] TYPE_STORE  = 2'd1;
  localparam logic [1:0] TYPE_BRANCH = 2'd2;

  // Per-entry state
  logic             ent_busy      [ROB_SIZE];
  logic             ent_ready     [ROB_SIZE];
  logic [1:0]       ent_type      [ROB_SIZE];
  logic [4:0]       ent_rd        [ROB_SIZE];
  logic [31:0]      ent_val       [ROB_SIZE];
  logic             ent_pred_jump [ROB_SIZE];
  logic             ent_jump      [ROB_SIZE];
  logic [31:0]      ent_addr      [ROB_SIZE];

  logic [TAG_W-1:0] head;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  logic commit_fire;
  logic head_is_store;
  logic head_is_branch;
  logic mispredict;
  logic issue_fire;
  logic cdb_fire;

  // Per-cycle decisions, all taken from registered state
  always_comb begin
    commit_fire    = ent_busy[head] && ent_ready[head];
    head_is_store  = (ent_type[head] == TYPE_STORE);
    head_is_branch = (ent_type[head] == TYPE_BRANCH);
    mispredict     = commit_fire && head_is_branch &&
                     (ent_jump[head] != ent_pred_jump[head]);
    issue_fire     = issue_valid && !rob_full && !rob_clear && !mispredict;
    cdb_fire       = cdb_valid && !rob_clear && ent_busy[cdb_tag];

    count_nxt = count;
    if (issue_fire && !commit_fire) begin
      count_nxt = count + CNT_W'(1);
    end else if (!issue_fire && commit_fire) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Entry array: CDB capture, retire release, allocation and flush
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < ROB_SIZE; i++) begin
        ent_busy[i]  <= 1'b0;
        ent_ready[i] <= 1'b0;
      end
    end else if (rdy_in) begin
      if (mispredict) begin
        for (int unsigned i = 0; i < ROB_SIZE; i++) begin
          ent_busy[i]  <= 1'b0;
          ent_ready[i] <= 1'b0;
        end
      end else begin
        if (cdb_fire) begin
          ent_ready[cdb_tag] <= 1'b1;
          ent_val[cdb_tag]   <= cdb_val;
          ent_jump[cdb_tag]  <= cdb_jump;
          ent_addr[cdb_tag]  <= cdb_addr;
        end
        if (commit_fire) begin
          ent_busy[head]  <= 1'b0;
          ent_ready[head] <= 1'b0;
        end
        if (issue_fire) begin
          ent_busy[rob_tail]      <= 1'b1;
          ent_ready[rob_tail]     <= issue_ready;
          ent_type[rob_tail]      <= issue_type;
          ent_rd[rob_tail]        <= issue_rd;
          ent_val[rob_tail]       <= issue_val;
          ent_pred_jump[rob_tail] <= issue_pred_jump;
          // A branch resolved at issue is taken as correctly predicted
          ent_jump[rob_tail]      <= issue_pred_jump;
          ent_addr[rob_tail]      <= 32'd0;
        end
      end
    end
  end

  // Head/tail pointers, occupancy and the registered full flag
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head     <= '0;
      rob_tail <= '0;
      count    <= '0;
      rob_full <= 1'b0;
    end else if (rdy_in) begin
      if (mispredict) begin
        head     <= '0;
        rob_tail <= '0;
        count    <= '0;
        rob_full <= 1'b0;
      end else begin
        if (commit_fire) begin
          head <= head + TAG_W'(1);
        end
        if (issue_fire) begin
          rob_tail <= rob_tail + TAG_W'(1);
        end
        count    <= count_nxt;
        rob_full <= (count_nxt == CNT_W'(ROB_SIZE));
      end
    end
  end

  // Retirement outputs: register write, store release and flush request
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rob_set_idx      <= 5'd0;
      rob_set_reg_val  <= 32'd0;
      rob_set_recorder <= '0;
      store_go         <= 1'b0;
      store_tag        <= '0;
      rob_clear        <= 1'b0;
      clear_pc         <= 32'd0;
    end else if (rdy_in) begin
      rob_set_idx <= 5'd0;
      store_go    <= 1'b0;
      rob_clear   <= 1'b0;
      if (commit_fire) begin
        if (head_is_store) begin
          store_go  <= 1'b1;
          store_tag <= head;
        end else if (!head_is_branch || (ent_rd[head] != 5'd0)) begin
          rob_set_idx      <= ent_rd[head];
          rob_set_reg_val  <= ent_val[head];
          rob_set_recorder <= head;
        end
        if (mispredict) begin
          rob_clear <= 1'b1;
          clear_pc  <= ent_addr[head];
        end
      end
    end
  end

`ifdef ROB_OPERAND_FWD_EN
  // Operand lookup for the decoder, bypassing a result broadcast this cycle
  always_comb begin
    qry_ready1 = ent_ready[qry_tag1];
    qry_val1   = ent_val[qry_tag1];
    qry_ready2 = ent_ready[qry_tag2];
    qry_val2   = ent_val[qry_tag2];
    if (cdb_valid && (cdb_tag == qry_tag1)) begin
      qry_ready1 = 1'b1;
      qry_val1   = cdb_val;
    end
    if (cdb_valid && (cdb_tag == qry_tag2)) begin
      qry_ready2 = 1'b1;
      qry_val2   = cdb_val;
    end
  end
`endif

endmodule
